// File: rtl/axi_mem_if_pkg.sv
// Shared encodings for the AXI4 single-port memory interface controllers:
// burst types, response codes and the write-channel FSM state.
package axi_mem_if_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'b00,
    WR_BURST = 2'b01,
    WR_RESP  = 2'b10
  } wr_state_e;

  // AXI only defines WRAP bursts of 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_mem_if_write_ctrl_if.sv
// AXI4 AW/W/B channel bundle between an AXI master and the write controller.
interface axi_mem_if_write_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int USER_W = 4
);
    localparam int NB = DATA_W / 8;

    // Every channel transfers on a rising edge where valid and ready are both high;
    // the source holds its payload stable while valid is high and ready is low.
    logic              awvalid_i;
    logic              awready_o;
    logic [ADDR_W-1:0] awaddr_i;
    logic [7:0]        awlen_i;
    logic [2:0]        awsize_i;
    logic [1:0]        awburst_i;
    logic [ID_W-1:0]   awid_i;
    logic [USER_W-1:0] awuser_i;

    logic              wvalid_i;
    logic              wready_o;
    logic [DATA_W-1:0] wdata_i;
    logic [NB-1:0]     wstrb_i;
    logic              wlast_i;

    logic              bvalid_o;
    logic              bready_i;
    logic [ID_W-1:0]   bid_o;
    logic [USER_W-1:0] buser_o;
    logic [1:0]        bresp_o;

    modport slave (
        input  awvalid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awid_i, awuser_i,
        input  wvalid_i, wdata_i, wstrb_i, wlast_i, bready_i,
        output awready_o, wready_o, bvalid_o, bid_o, buser_o, bresp_o
    );

    modport master (
        output awvalid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awid_i, awuser_i,
        output wvalid_i, wdata_i, wstrb_i, wlast_i, bready_i,
        input  awready_o, wready_o, bvalid_o, bid_o, buser_o, bresp_o
    );
endinterface

// File: rtl/axi_mem_if_addr_gen.sv
// Next memory word address for one AXI beat; purely combinational so both the
// write and read controllers can step their latched address with it.
module axi_mem_if_addr_gen
  import axi_mem_if_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        burst_i,
    input  logic [7:0]        len_i,
    output logic [ADDR_W-1:0] next_addr_o
);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] wrap_mask;

    assign inc       = addr_i + ADDR_W'(1);
    assign wrap_mask = ADDR_W'(len_i[3:0]);

    // An illegal WRAP length degrades to INCR; the controller flags the error.
    always_comb begin
        next_addr_o = inc;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP: begin
                if (wrap_len_ok(len_i)) next_addr_o = (addr_i & ~wrap_mask) | (inc & wrap_mask);
            end
            default: next_addr_o = inc;
        endcase
    end
endmodule

// File: rtl/axi_mem_if_write_ctrl.sv
// AXI4 write-channel slave: turns each granted W beat into one single-port
// memory write in the same cycle and answers each burst with one B response.
module axi_mem_if_write_ctrl
  import axi_mem_if_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_WDATA_WIDTH   = 32,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int AXI4_USER_WIDTH    = 4,
    parameter int AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH     = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    axi_mem_if_write_ctrl_if.slave      axi,
    output logic                        valid_o,
    input  logic                        grant_i,
    output logic                        mem_cen_o,
    output logic                        mem_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [AXI4_WDATA_WIDTH-1:0] mem_wdata_o,
    output logic [AXI_NUMBYTES-1:0]     mem_be_o,
    output wr_state_e                   state_o
);
    localparam int OFFS = $clog2(AXI_NUMBYTES);

    wr_state_e                  state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [7:0]                 len_q, len_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [1:0]                 burst_q, burst_d;
    logic [AXI4_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXI4_USER_WIDTH-1:0] user_q, user_d;
    logic                       err_q, err_d;

    logic                      beat;
    logic                      last_beat;
    logic [MEM_ADDR_WIDTH-1:0] next_addr;
    logic                      unused_ok;

    axi_mem_if_addr_gen #(.ADDR_W(MEM_ADDR_WIDTH)) u_addr_gen (
        .addr_i      (addr_q),
        .burst_i     (burst_q),
        .len_i       (len_q),
        .next_addr_o (next_addr)
    );

    // A beat completes in the very cycle the mux grants it; nothing is buffered.
    assign beat      = (state_q == WR_BURST) && axi.wvalid_i && grant_i;
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        id_d    = id_q;
        user_d  = user_q;
        err_d   = err_q;
        case (state_q)
            WR_IDLE: begin
                if (axi.awvalid_i) begin
                    addr_d  = axi.awaddr_i[MEM_ADDR_WIDTH+OFFS-1 -: MEM_ADDR_WIDTH];
                    len_d   = axi.awlen_i;
                    burst_d = axi.awburst_i;
                    id_d    = axi.awid_i;
                    user_d  = axi.awuser_i;
                    cnt_d   = 8'd0;
                    err_d   = (axi.awburst_i == BURST_WRAP) && !wrap_len_ok(axi.awlen_i);
                    state_d = WR_BURST;
                end
            end
            WR_BURST: begin
                if (beat) begin
                    if (axi.wlast_i != last_beat) err_d = 1'b1;
                    // The beat count, not wlast, decides where the burst ends.
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        addr_d = next_addr;
                        cnt_d  = cnt_q + 8'd1;
                    end
                end
            end
            WR_RESP: begin
                if (axi.bready_i) state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WR_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            burst_q <= BURST_INCR;
            id_q    <= '0;
            user_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            user_q  <= user_d;
            err_q   <= err_d;
        end
    end

    // Memory-side outputs are gated by state, so reset releases the bus at once.
    assign axi.awready_o = (state_q == WR_IDLE);
    assign axi.wready_o  = beat;
    assign axi.bvalid_o  = (state_q == WR_RESP);
    assign axi.bresp_o   = ((state_q == WR_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi.bid_o     = id_q;
    assign axi.buser_o   = user_q;

    assign valid_o     = (state_q == WR_BURST) && axi.wvalid_i;
    assign mem_cen_o   = ~beat;
    assign mem_wen_o   = 1'b0;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = axi.wdata_i;
    assign mem_be_o    = axi.wstrb_i;
    assign state_o     = state_q;

    // Only full-width beats exist, so size and the byte offset carry no information.
    assign unused_ok = ^{axi.awsize_i, axi.awaddr_i};
endmodule

// File: tb/tb_axi_mem_if_write_ctrl.sv
// Directed plus randomized bench for axi_mem_if_write_ctrl with an
// address-sequence reference model and a memory-write scoreboard.
module tb_axi_mem_if_write_ctrl;
  import axi_mem_if_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 13;
  localparam int EW = MW + DW + 4;

  logic clk;
  logic rst_n;
  logic grant_i;
  logic valid_o;
  logic mem_cen_o;
  logic mem_wen_o;
  logic [MW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0] mem_be_o;
  wr_state_e state_dbg;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [EW-1:0] exp_q[$];

  logic [31:0] cur_addr;
  int cur_len;
  logic [1:0] cur_burst;
  logic [3:0] cur_id;
  logic [3:0] cur_user;

  axi_mem_if_write_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(4), .USER_W(4)) axi_bus ();

  axi_mem_if_write_ctrl #(
    .AXI4_ADDRESS_WIDTH(AW), .AXI4_WDATA_WIDTH(DW), .AXI4_ID_WIDTH(4),
    .AXI4_USER_WIDTH(4), .MEM_ADDR_WIDTH(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .axi(axi_bus), .valid_o(valid_o), .grant_i(grant_i),
    .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .state_o(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: word address of a given beat, from the AXI burst rules
  function automatic logic [MW-1:0] model_addr(input logic [31:0] byte_addr, input int len,
                                               input logic [1:0] burst, input int beat);
    int unsigned start;
    int unsigned n;
    int unsigned base;
    start = (byte_addr / 4) % 8192;
    if (burst == 2'b00) return MW'(start);
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      n = len + 1;
      base = start - (start % n);
      return MW'(base + ((start % n) + beat) % n);
    end
    return MW'((start + beat) % 8192);
  endfunction

  // scoreboard: every memory write must match the oldest expected beat
  always @(negedge clk) begin
    if (rst_n && mem_cen_o === 1'b0) begin
      wr_cnt++;
      chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        chk("mem_write", 64'({mem_addr_o, mem_wdata_o, mem_be_o}), 64'(exp_q.pop_front()));
        chk("mem_wen", 64'(mem_wen_o), 64'd0);
        chk("valid_on_write", 64'(valid_o), 64'd1);
      end
    end
  end

  // driver tasks
  task automatic aw_set(input logic [31:0] addr, input int len, input logic [1:0] burst,
                        input logic [3:0] id, input logic [3:0] user);
    axi_bus.awvalid_i = 1'b1;
    axi_bus.awaddr_i  = addr;
    axi_bus.awlen_i   = 8'(len);
    axi_bus.awsize_i  = 3'd2;
    axi_bus.awburst_i = burst;
    axi_bus.awid_i    = id;
    axi_bus.awuser_i  = user;
  endtask

  task automatic aw_wait();
    int n;
    n = 0;
    while (axi_bus.awready_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("aw_accept_timeout", 64'(axi_bus.awready_o), 64'd1);
    @(posedge clk); #1;
    cur_addr  = axi_bus.awaddr_i;
    cur_len   = int'(axi_bus.awlen_i);
    cur_burst = axi_bus.awburst_i;
    cur_id    = axi_bus.awid_i;
    cur_user  = axi_bus.awuser_i;
    axi_bus.awvalid_i = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic send_w(input int early_last, input bit drop_last, input int stall_beat,
                        input int stall_n, input bit rnd, output bit w_err);
    int stalls;
    logic is_last;
    w_err = 1'b0;
    for (int b = 0; b <= cur_len; b++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        axi_bus.wvalid_i = 1'b0;
        grant_i = 1'($urandom_range(0, 1));
        #1;
        chk("valid_idle", 64'(valid_o), 64'd0);
        chk("wready_idle", 64'(axi_bus.wready_o), 64'd0);
        @(posedge clk); #1;
      end
      is_last = (b == cur_len);
      axi_bus.wvalid_i = 1'b1;
      axi_bus.wdata_i  = $urandom;
      axi_bus.wstrb_i  = 4'($urandom_range(0, 15));
      axi_bus.wlast_i  = is_last ? !drop_last : (b == early_last);
      if (axi_bus.wlast_i != is_last) w_err = 1'b1;
      stalls = (b == stall_beat) ? stall_n : (rnd ? $urandom_range(0, 2) : 0);
      for (int s = 0; s < stalls; s++) begin
        grant_i = 1'b0;
        #1;
        chk("stall_wready", 64'(axi_bus.wready_o), 64'd0);
        chk("stall_valid", 64'(valid_o), 64'd1);
        chk("stall_cen", 64'(mem_cen_o), 64'd1);
        @(posedge clk); #1;
      end
      grant_i = 1'b1;
      exp_q.push_back({model_addr(cur_addr, cur_len, cur_burst, b), axi_bus.wdata_i, axi_bus.wstrb_i});
      #1;
      chk("beat_wready", 64'(axi_bus.wready_o), 64'd1);
      @(posedge clk); #1;
    end
    axi_bus.wvalid_i = 1'b0;
    axi_bus.wlast_i  = 1'b0;
    grant_i = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] exp_resp, input int hold);
    int n;
    n = 0;
    axi_bus.bready_i = 1'b0;
    while (axi_bus.bvalid_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bvalid_timeout", 64'(axi_bus.bvalid_o), 64'd1);
    for (int h = 0; h < hold; h++) begin
      chk("b_hold_bvalid", 64'(axi_bus.bvalid_o), 64'd1);
      chk("b_hold_awready", 64'(axi_bus.awready_o), 64'd0);
      @(posedge clk); #1;
    end
    chk("write_count", 64'(wr_cnt), 64'(cur_len + 1));
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("bresp", 64'(axi_bus.bresp_o), 64'(exp_resp));
    chk("bid", 64'(axi_bus.bid_o), 64'(cur_id));
    chk("buser", 64'(axi_bus.buser_o), 64'(cur_user));
    axi_bus.bready_i = 1'b1;
    @(posedge clk); #1;
    axi_bus.bready_i = 1'b0;
    chk("b_done_bvalid", 64'(axi_bus.bvalid_o), 64'd0);
    chk("b_done_awready", 64'(axi_bus.awready_o), 64'd1);
  endtask

  task automatic run_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input int early_last, input bit drop_last, input int stall_beat,
                           input int stall_n, input bit rnd, input int hold);
    bit w_err;
    bit bad_wrap;
    aw_set(addr, len, burst, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    aw_wait();
    send_w(early_last, drop_last, stall_beat, stall_n, rnd, w_err);
    bad_wrap = (burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15);
    do_b((w_err || bad_wrap) ? 2'b10 : 2'b00, hold);
  endtask

  initial begin
    bit w_err;
    rst_n = 1'b0;
    grant_i = 1'b0;
    axi_bus.awvalid_i = 1'b0; axi_bus.awaddr_i = '0; axi_bus.awlen_i = '0;
    axi_bus.awsize_i = 3'd2; axi_bus.awburst_i = 2'b01; axi_bus.awid_i = '0; axi_bus.awuser_i = '0;
    axi_bus.wvalid_i = 1'b0; axi_bus.wdata_i = '0; axi_bus.wstrb_i = '0; axi_bus.wlast_i = 1'b0;
    axi_bus.bready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(axi_bus.awready_o), 64'd1);
    chk("rst_wready", 64'(axi_bus.wready_o), 64'd0);
    chk("rst_bvalid", 64'(axi_bus.bvalid_o), 64'd0);
    chk("rst_bresp", 64'(axi_bus.bresp_o), 64'd0);
    chk("rst_bid", 64'(axi_bus.bid_o), 64'd0);
    chk("rst_buser", 64'(axi_bus.buser_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_cen", 64'(mem_cen_o), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single beat at 0x40 -> word 0x10
    run_burst(32'h40, 0, 2'b01, -1, 1'b0, -1, 0, 1'b0, 0);
    // INCR len 3 from 0x100 with beat 2 stalled 3 cycles
    run_burst(32'h100, 3, 2'b01, -1, 1'b0, 2, 3, 1'b0, 0);
    // WRAP len 3 from 0x08 -> 2,3,0,1
    run_burst(32'h08, 3, 2'b10, -1, 1'b0, -1, 0, 1'b0, 0);
    // FIXED len 2 at 0x20
    run_burst(32'h20, 2, 2'b00, -1, 1'b0, -1, 0, 1'b0, 0);
    // early wlast on beat 1
    run_burst(32'h300, 3, 2'b01, 1, 1'b0, -1, 0, 1'b0, 0);
    // missing wlast on the final beat
    run_burst(32'h400, 2, 2'b01, -1, 1'b1, -1, 0, 1'b0, 0);
    // illegal WRAP length runs as INCR and reports SLVERR
    run_burst(32'h44, 2, 2'b10, -1, 1'b0, -1, 0, 1'b0, 0);
    // INCR crossing the top of the word space
    run_burst(32'h7FF8, 3, 2'b01, -1, 1'b0, -1, 0, 1'b0, 0);

    // next AW pending while B is held off for 5 cycles
    aw_set(32'h500, 1, 2'b01, 4'h9, 4'h2);
    aw_wait();
    send_w(-1, 1'b0, -1, 0, 1'b0, w_err);
    aw_set(32'h600, 1, 2'b01, 4'hA, 4'h6);
    do_b(w_err ? 2'b10 : 2'b00, 5);
    aw_wait();
    send_w(-1, 1'b0, -1, 0, 1'b0, w_err);
    do_b(w_err ? 2'b10 : 2'b00, 0);

    // reset asserted during beat 2 of a burst
    aw_set(32'h200, 3, 2'b01, 4'h3, 4'h1);
    aw_wait();
    for (int b = 0; b < 2; b++) begin
      axi_bus.wvalid_i = 1'b1; axi_bus.wdata_i = $urandom; axi_bus.wstrb_i = 4'hF;
      axi_bus.wlast_i = 1'b0; grant_i = 1'b1;
      exp_q.push_back({model_addr(cur_addr, cur_len, cur_burst, b), axi_bus.wdata_i, axi_bus.wstrb_i});
      @(posedge clk); #1;
    end
    axi_bus.wdata_i = $urandom;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_cen", 64'(mem_cen_o), 64'd1);
    chk("midrst_bvalid", 64'(axi_bus.bvalid_o), 64'd0);
    chk("midrst_awready", 64'(axi_bus.awready_o), 64'd1);
    chk("midrst_wready", 64'(axi_bus.wready_o), 64'd0);
    chk("midrst_writes", 64'(wr_cnt), 64'd2);
    axi_bus.wvalid_i = 1'b0; grant_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_b", 64'(axi_bus.bvalid_o), 64'd0);
    end
    run_burst(32'h240, 1, 2'b01, -1, 1'b0, -1, 0, 1'b0, 0);

    // randomized bursts
    for (int i = 0; i < 30; i++) begin
      logic [1:0] br;
      int len;
      logic [31:0] addr;
      br = 2'($urandom_range(0, 2));
      len = (br == 2'b10) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      addr = ($urandom_range(0, 4) == 0) ? 32'h7FF0 + 32'($urandom_range(0, 15)) : $urandom;
      run_burst(addr, len, br,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1,
                1'($urandom_range(0, 5) == 0), -1, 0, 1'b1, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
